// File: rtl/uno_pkg.sv
// uno_pkg: shared card encoding, draw commands and scheduler state for the UNO deck controller.
package uno_pkg;
  typedef logic [5:0] card_t;
  localparam logic [1:0] RED = 2'd0, YELLOW = 2'd1, GREEN = 2'd2, BLUE = 2'd3;
  localparam logic [3:0] V_SKIP = 4'd10, V_REVERSE = 4'd11, V_DRAW2 = 4'd12, V_WILD = 4'd13, V_WILD4 = 4'd14;
  localparam logic [2:0] CMD_DRAW1 = 3'b001, CMD_DRAW2 = 3'b010, CMD_DRAW4 = 3'b100;
  typedef enum logic [2:0] {
    S_IDLE, S_SHUFFLE, S_DEAL, S_DEAL_WAIT, S_ARB, S_SERVE, S_SERVE_WAIT, S_GRANT
  } state_t;
  function automatic logic [2:0] dec_cnt(input logic [2:0] c);
    return (c == 3'b010) ? 3'd2 : (c == 3'b100) ? 3'd4 : 3'd1;
  endfunction
endpackage

// File: rtl/uno_rr_arbiter.sv
// uno_rr_arbiter: combinational round-robin pick of the first set request at or after ptr, with wrap.
module uno_rr_arbiter #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);
  logic [PW-1:0] c;
  always_comb begin
    valid = |req;
    idx = ptr;
    c = ptr;
    for (int i = N - 1; i >= 0; i--) begin
      c = PW'((int'(ptr) + i) % N);
      if (req[c]) idx = c;
    end
  end
endmodule

// File: rtl/uno_draw_sched.sv
// uno_draw_sched: starts the deck shuffle, deals opening hands round-robin, then serves
// 1/2/4-card draw requests round-robin, routing each card to its requester.
module uno_draw_sched
  import uno_pkg::*;
#(
  parameter int NUM_PLAYERS = 4,
  parameter int HAND_INIT = 7,
  parameter int TIMEOUT = 255,
  localparam int PW = $clog2(NUM_PLAYERS)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [NUM_PLAYERS-1:0]   i_req,
  input  logic [3*NUM_PLAYERS-1:0] i_req_cnt,
  output logic                     o_deck_start,
  output logic [2:0]               o_deck_draw,
  input  logic                     i_deck_done,
  input  logic                     i_deck_drawn,
  input  logic [5:0]               i_deck_card,
  output logic                     o_card_valid,
  output logic [5:0]               o_card,
  output logic [PW-1:0]            o_card_dst,
  output logic [NUM_PLAYERS-1:0]   o_grant,
  output logic                     o_deal_done,
  output logic                     o_busy,
  output logic                     o_timeout
);
  localparam int TOTAL = NUM_PLAYERS * HAND_INIT;
  localparam int DW = $clog2(TOTAL + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t state, state_n;
  logic [WW-1:0] wd;
  logic [DW-1:0] deal_cnt;
  logic [PW-1:0] deal_dst, rr_ptr, cur_p, arb_idx, dst_r;
  logic [2:0] remaining;
  card_t card_r;
  logic [NUM_PLAYERS-1:0] arb_req, grant_r;
  logic [2:0] req_cnt [NUM_PLAYERS];
  logic arb_valid, valid_r, deal_done_r, deck_start_r, draw_r, timeout_r;
  logic start_acc, fetch_go, got, abort, grab, wd_exp, last_deal;

  always_comb
    for (int i = 0; i < NUM_PLAYERS; i++) req_cnt[i] = i_req_cnt[3*i +: 3];

  // the player just granted is masked for one cycle while its request line drops
  assign arb_req = i_req & ~grant_r & {NUM_PLAYERS{deal_done_r}};
  assign wd_exp = wd == WW'(TIMEOUT - 1);
  assign last_deal = deal_cnt == DW'(TOTAL - 1);

  uno_rr_arbiter #(.N(NUM_PLAYERS)) u_arb (
    .req(arb_req),
    .ptr(rr_ptr),
    .valid(arb_valid),
    .idx(arb_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= S_IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    fetch_go = 1'b0;
    got = 1'b0;
    abort = 1'b0;
    grab = 1'b0;
    start_acc = i_start && (state == S_IDLE || state == S_ARB);
    case (state)
      S_IDLE: if (i_start) state_n = S_SHUFFLE;
      S_SHUFFLE: if (wd > WW'(1) && i_deck_done) state_n = S_DEAL;
      S_DEAL, S_SERVE: if (i_deck_done) begin
        fetch_go = 1'b1;
        state_n = (state == S_DEAL) ? S_DEAL_WAIT : S_SERVE_WAIT;
      end
      S_DEAL_WAIT: if (i_deck_drawn) begin
        got = 1'b1;
        state_n = last_deal ? S_ARB : S_DEAL;
      end else if (wd_exp) begin
        abort = 1'b1;
        state_n = S_IDLE;
      end
      S_ARB: if (i_start) state_n = S_SHUFFLE;
        else if (arb_valid) begin
          grab = 1'b1;
          state_n = S_SERVE;
        end
      S_SERVE_WAIT: if (i_deck_drawn) begin
        got = 1'b1;
        state_n = (remaining == 3'd1) ? S_GRANT : S_SERVE;
      end else if (wd_exp) begin
        abort = 1'b1;
        state_n = S_GRANT;
      end
      S_GRANT: state_n = S_ARB;
      default: state_n = S_IDLE;
    endcase
  end

  // watchdog restarts on every state change, so in a wait state it counts cycles spent there
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wd <= '0;
      deal_cnt <= '0;
      deal_dst <= '0;
      rr_ptr <= '0;
      cur_p <= '0;
      remaining <= '0;
      card_r <= '0;
      dst_r <= '0;
      valid_r <= 1'b0;
      grant_r <= '0;
      deal_done_r <= 1'b0;
      deck_start_r <= 1'b0;
      draw_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      wd <= (state_n != state) ? '0 : (wd == '1) ? wd : wd + 1'b1;
      deck_start_r <= start_acc;
      draw_r <= fetch_go;
      valid_r <= got;
      timeout_r <= abort;
      grant_r <= (state == S_GRANT) ? NUM_PLAYERS'(1) << cur_p : '0;
      if (got) begin
        card_r <= i_deck_card;
        dst_r <= (state == S_DEAL_WAIT) ? deal_dst : cur_p;
      end
      if (start_acc) begin
        deal_done_r <= 1'b0;
        deal_cnt <= '0;
        deal_dst <= '0;
        rr_ptr <= '0;
      end
      if (got && state == S_DEAL_WAIT) begin
        deal_cnt <= deal_cnt + 1'b1;
        deal_dst <= (deal_dst == PW'(NUM_PLAYERS - 1)) ? '0 : deal_dst + 1'b1;
        if (last_deal) deal_done_r <= 1'b1;
      end
      if (grab) begin
        cur_p <= arb_idx;
        remaining <= dec_cnt(req_cnt[arb_idx]);
      end
      if (got && state == S_SERVE_WAIT) remaining <= remaining - 1'b1;
      if (state == S_GRANT) rr_ptr <= (cur_p == PW'(NUM_PLAYERS - 1)) ? '0 : cur_p + 1'b1;
    end

  assign o_deck_start = deck_start_r;
  assign o_deck_draw = draw_r ? CMD_DRAW1 : 3'b000;
  assign o_card_valid = valid_r;
  assign o_card = card_r;
  assign o_card_dst = dst_r;
  assign o_grant = grant_r;
  assign o_deal_done = deal_done_r;
  assign o_busy = !(state == S_IDLE || state == S_ARB);
  assign o_timeout = timeout_r;
endmodule

// File: tb/tb_uno_draw_sched.sv
// tb_uno_draw_sched: scoreboard bench with a behavioural deck and player models around uno_draw_sched.
module tb_uno_draw_sched;
  import uno_pkg::*;

  logic i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_deck_done = 1'b1, i_deck_drawn = 1'b0;
  logic [3:0] i_req = '0;
  logic [11:0] i_req_cnt = '0;
  logic [5:0] i_deck_card = '0;
  logic o_deck_start, o_card_valid, o_deal_done, o_busy, o_timeout;
  logic [2:0] o_deck_draw;
  logic [5:0] o_card;
  logic [1:0] o_card_dst;
  logic [3:0] o_grant;

  uno_draw_sched #(.NUM_PLAYERS(4), .HAND_INIT(7), .TIMEOUT(255)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_req(i_req), .i_req_cnt(i_req_cnt),
    .o_deck_start(o_deck_start), .o_deck_draw(o_deck_draw), .i_deck_done(i_deck_done),
    .i_deck_drawn(i_deck_drawn), .i_deck_card(i_deck_card), .o_card_valid(o_card_valid),
    .o_card(o_card), .o_card_dst(o_card_dst), .o_grant(o_grant), .o_deal_done(o_deal_done),
    .o_busy(o_busy), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // kind: 0 deck start, 1 card {dst,card}, 2 grant, 3 timeout; gap = required cycles since previous event
  typedef struct {int kind; logic [7:0] data; int gap;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, cyc = 0, last_cyc = 0, deck_budget = -1, pend = 0, shuf = 0;
  logic [5:0] deck_seq = '0, exp_seq = '0;

  task automatic push(int k, logic [7:0] d, int g);
    exp_t e;
    e.kind = k; e.data = d; e.gap = g;
    q.push_back(e);
  endtask

  task automatic push_card(int dst);
    push(1, {2'(dst), exp_seq}, 0);
    exp_seq = exp_seq + 6'd1;
  endtask

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic see(int k, logic [7:0] d);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d data=%h at cycle %0d, expected none", k, d, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.data !== d || (e.gap != 0 && cyc - last_cyc != e.gap)) begin
        failures++;
        $display("FAIL event: got kind=%0d data=%h gap=%0d expected kind=%0d data=%h gap=%0d",
                 k, d, cyc - last_cyc, e.kind, e.data, e.gap);
      end
    end
    last_cyc = cyc;
  endtask

  task automatic drain(int max, string n);
    int k = 0;
    while (q.size() != 0 && k < max) begin
      @(negedge i_clk);
      k++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got %0d events outstanding after %0d cycles, expected 0", n, q.size(), max);
      q.delete();
    end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic req(int p, logic [2:0] c);
    i_req_cnt[3*p +: 3] = c;
    i_req[p] = 1'b1;
  endtask

  // monitor; also models each player dropping its request on its grant
  initial forever begin
    @(negedge i_clk);
    cyc++;
    if (o_deck_start) see(0, 8'h00);
    if (o_card_valid) see(1, {o_card_dst, o_card});
    if (o_timeout) see(3, 8'h00);
    if (o_grant != 4'b0) begin
      see(2, {4'h0, o_grant});
      i_req = i_req & ~o_grant;
    end
  end

  // deck: busy 5 cycles after a shuffle start, drawn strobe 3 cycles after each draw command
  initial forever begin
    @(negedge i_clk);
    i_deck_drawn = 1'b0;
    if (o_deck_start) begin
      i_deck_done = 1'b0;
      shuf = 5;
    end else if (shuf > 0) begin
      shuf--;
      if (shuf == 0) i_deck_done = 1'b1;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        i_deck_drawn = 1'b1;
        i_deck_card = deck_seq;
        deck_seq = deck_seq + 6'd1;
      end
    end
    if (o_deck_draw != 3'b000) begin
      chk("deck_draw_cmd", 32'(o_deck_draw), 32'(CMD_DRAW1));
      if (deck_budget != 0) begin
        pend = 3;
        if (deck_budget > 0) deck_budget--;
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge i_clk);
    chk("reset_outputs", 32'({o_deck_start, o_deck_draw, o_card_valid, o_card, o_card_dst, o_grant,
                             o_deal_done, o_busy, o_timeout}), 32'h0);
    chk("reset_state", 32'(dut.state), 32'(S_IDLE));
    i_rst_n = 1'b1;
    @(negedge i_clk);

    push(0, 8'h00, 0);
    for (int i = 0; i < 28; i++) push_card(i % 4);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    drain(3000, "deal");
    chk("deal_done", 32'(o_deal_done), 32'd1);
    chk("busy_after_deal", 32'(o_busy), 32'd0);

    push_card(2); push_card(2); push(2, 8'h04, 1);
    req(2, 3'b010);
    drain(200, "p2_draw2");
    chk("rr_ptr_after_p2", 32'(dut.rr_ptr), 32'd3);

    push_card(3); push(2, 8'h08, 1); push_card(0); push(2, 8'h01, 1);
    req(0, 3'b001);
    req(3, 3'b001);
    drain(200, "p3_then_p0");
    chk("rr_ptr_after_pair", 32'(dut.rr_ptr), 32'd1);

    deck_budget = 2;
    push_card(1); push_card(1); push(3, 8'h00, 256); push(2, 8'h02, 1);
    req(1, 3'b100);
    drain(1000, "p1_timeout");
    deck_budget = -1;

    push_card(0); push(2, 8'h01, 1);
    req(0, 3'b011);
    drain(200, "p0_invalid_cnt");

    for (int i = 0; i < 4; i++) push_card(3);
    push(2, 8'h08, 1);
    req(3, 3'b100);
    repeat (4) @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    drain(300, "start_in_serve");
    chk("deal_done_kept", 32'(o_deal_done), 32'd1);

    deck_budget = 0;
    req(2, 3'b001);
    n = 0;
    while (o_deck_draw == 3'b000 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    chk("draw_before_reset", 32'(o_deck_draw), 32'(CMD_DRAW1));
    #1 i_rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({o_deck_start, o_deck_draw, o_card_valid, o_card, o_card_dst, o_grant,
                                   o_deal_done, o_busy, o_timeout}), 32'h0);
    chk("async_reset_state", 32'(dut.state), 32'(S_IDLE));
    i_req = '0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    deck_budget = -1;
    repeat (20) @(negedge i_clk);
    chk("idle_after_reset", 32'(o_busy), 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uno_draw_sched.md
Name: uno_draw_sched

Overview:
- Controller that sequences the shared two-bank UNO deck for the game.
- On a new game it starts the deck shuffle, then deals the opening hands round-robin.
- It then arbitrates draw requests (1/2/4 cards) from the players and routes each drawn card to the requesting player's hand logic.
- Sits between the per-player hand/turn logic and the deck; it is the only block that drives the deck's start/draw inputs.

Parameters:
- NUM_PLAYERS, 4, number of players / requesters (2..8).
- HAND_INIT, 7, cards dealt to each player at game start.
- TIMEOUT, 255, maximum cycles to wait for the deck's drawn strobe before aborting a card fetch.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  new-game pulse.
- i_req  in  NUM_PLAYERS  per-player draw request; level, held until that player's o_grant bit pulses.
- i_req_cnt  in  3*NUM_PLAYERS  per-player one-hot count, in slice [3p+2:3p]: 001 = 1 card, 010 = 2 cards, 100 = 4 cards.
- o_deck_start  out  1  one-cycle shuffle start to the deck.
- o_deck_draw  out  3  deck draw command; only 3'b001 (single card) or 3'b000 is ever driven.
- i_deck_done  in  1  deck idle/ready.
- i_deck_drawn  in  1  deck strobe: i_deck_card is valid this cycle.
- i_deck_card  in  6  {color[1:0], value[3:0]} from the deck.
- o_card_valid  out  1  one-cycle strobe: o_card and o_card_dst are valid.
- o_card  out  6  routed card.
- o_card_dst  out  $clog2(NUM_PLAYERS)  destination player index.
- o_grant  out  NUM_PLAYERS  one-hot pulse when a player's whole request has completed.
- o_deal_done  out  1  high once dealing has finished; held until the next accepted i_start.
- o_busy  out  1  high in every state except S_IDLE and S_ARB.
- o_timeout  out  1  one-cycle pulse when a card fetch aborts.

Behaviour:
- Reset: state S_IDLE, rr_ptr = 0; all outputs 0, except o_card and o_card_dst, which are 0 and don't-care.
- Card fetch (shared sub-sequence):
  - FETCH_REQ waits for i_deck_done = 1, then drives o_deck_draw = 001 for exactly one cycle.
  - FETCH_WAIT waits for i_deck_drawn and captures i_deck_card.
  - o_card_valid pulses the cycle after capture; latency from drawn strobe to o_card_valid is 1 cycle.
  - A watchdog counts cycles in FETCH_WAIT. On reaching TIMEOUT without a drawn strobe: o_timeout pulses, no o_card_valid is issued, and the current transaction is aborted.
- States and transitions:
  - S_IDLE: on i_start, pulse o_deck_start, clear o_deal_done, go to S_SHUFFLE.
  - S_SHUFFLE: ignore i_deck_done for 2 cycles (deck leaves idle), then wait for i_deck_done = 1; go to S_DEAL.
  - S_DEAL: fetch NUM_PLAYERS*HAND_INIT cards; destination is card_index mod NUM_PLAYERS, so the order is 0,1,2,3,0,...
    - After the last card: set o_deal_done, go to S_ARB.
    - On timeout: go to S_IDLE with o_deal_done = 0.
  - S_ARB: grant the first requester with set i_req bit, searching from rr_ptr upward with wrap.
    - Latch its index and count. Count decodes 001→1, 010→2, 100→4; zero or multi-hot decodes as 1.
    - Go to S_SERVE. With no requests, stay in S_ARB.
  - S_SERVE: fetch `remaining` cards, all to the latched player.
    - After the last o_card_valid: pulse o_grant[p] in the next cycle, set rr_ptr = (p+1) mod NUM_PLAYERS, return to S_ARB.
    - On timeout: pulse o_grant[p] anyway (request retired short), advance rr_ptr, go to S_ARB.
- Boundary conditions:
  - i_start is accepted only in S_IDLE or S_ARB. In S_ARB it behaves as from S_IDLE, and rr_ptr resets to 0. It is ignored in all other states.
  - i_req is ignored before o_deal_done. A request deasserted mid-service does not cancel the service.
  - Simultaneous requests: strict round-robin; the player served last has lowest priority next round.
  - Deck exhaustion is the deck's concern; the scheduler only waits on i_deck_done, and the watchdog bounds that wait.
  - Asynchronous reset mid-fetch returns to S_IDLE. No o_card_valid or o_grant is issued after reset.
- Widths:
  - Deal counter: $clog2(NUM_PLAYERS*HAND_INIT+1) bits.
  - Remaining counter: 3 bits.
  - Watchdog: $clog2(TIMEOUT+1) bits, saturating.

Decomposition:
- Shared package uno_pkg:
  - card type: 6-bit {color, value}.
  - color constants RED=0, YELLOW=1, GREEN=2, BLUE=3.
  - value constants SKIP=10, REVERSE=11, DRAW2=12, WILD=13, WILD4=14.
  - draw-command constants DRAW1=3'b001, DRAW2=3'b010, DRAW4=3'b100.
  - scheduler state enum.
- One natural sub-module, uno_rr_arbiter: combinational round-robin pick from i_req and rr_ptr, with index output. The pointer register stays in the parent.

Test Plan:
- Reset, then i_start with a deck model (done after 5 cycles, drawn 3 cycles after each draw) → exactly 28 o_card_valid, dst sequence 0,1,2,3 repeating; o_deal_done rises after the 28th; o_deck_draw is never anything other than 001.
- After deal, player 2 requests count 010 → two cards to dst 2, then o_grant = 4'b0100 one cycle after the 2nd card; rr_ptr = 3.
- Players 0 and 3 request simultaneously with rr_ptr = 3 → player 3 served first, then player 0; grants in that order.
- Player 1 requests 100 and the deck withholds drawn after the 2nd card → o_timeout after 255 cycles, o_grant = 0010, only 2 cards delivered.
- i_start asserted during S_SERVE → ignored. Asynchronous reset mid-FETCH_WAIT → outputs 0 immediately, state S_IDLE, no stray o_card_valid.
- Invalid count 011 from player 0 → exactly 1 card delivered, then the grant pulses.
